// File: rtl/evt_fifo_gen_if.sv
// Write/read handshake and status bundle between an event producer/consumer
// and evt_fifo_gen; the FIFO itself takes the slave modport.
interface evt_fifo_gen_if #(
    parameter int W  = 33,
    parameter int AW = 14
);
    logic [W-1:0] data_i;
    logic         we_i;
    logic         re_i;
    logic [W-1:0] data_o;
    logic         empty_o;
    logic         full_o;
    logic [AW:0]  level_o;
    logic         watermark_high_o;
    logic         watermark_low_o;
    logic         throttle_o;
    logic [AW:0]  evt_cnt_o;
    logic         evt_avail_o;
    logic         overflow_o;
    logic         underflow_o;

    modport slave (
        input  data_i, we_i, re_i,
        output data_o, empty_o, full_o, level_o, watermark_high_o,
               watermark_low_o, throttle_o, evt_cnt_o, evt_avail_o,
               overflow_o, underflow_o
    );

    modport master (
        output data_i, we_i, re_i,
        input  data_o, empty_o, full_o, level_o, watermark_high_o,
               watermark_low_o, throttle_o, evt_cnt_o, evt_avail_o,
               overflow_o, underflow_o
    );
endinterface

// File: rtl/evt_fifo_gen.sv
// Parametrised event FIFO on inferred dual-port RAM with normal or show-ahead
// read, fill level, watermarks, hysteretic throttle and complete-event count.
module evt_fifo_gen #(
    parameter int W         = 33,
    parameter int AW        = 14,
    parameter int HIGH      = (1 << AW) - 1024,
    parameter int LOW       = 1 << (AW - 1),
    parameter bit SHOWAHEAD = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    evt_fifo_gen_if.slave bus
);
    localparam int N = 1 << AW;
    localparam logic [AW:0] N_V    = (AW+1)'(N);
    localparam logic [AW:0] HIGH_V = (AW+1)'(HIGH);
    localparam logic [AW:0] LOW_V  = (AW+1)'(LOW);
    localparam logic [AW:0] ONE_V  = (AW+1)'(1);

    logic [W-1:0]  mem [N];
    // Shadow of the EOE bits so the count can drop in the same cycle as the pop.
    logic          eoe_mem [N];

    logic [AW-1:0] wptr, hptr;
    logic [AW:0]   level, level_nxt, evt_cnt, evt_nxt;
    logic          wa, ra, evt_inc, evt_dec;
    logic          empty_q, full_q, wm_high_q, wm_low_q, throttle_q;
    logic          avail_q, ovf_q, udf_q, out_vld_nxt;
    logic [W-1:0]  data_q;

    assign ra      = bus.re_i & ~empty_q;
    assign wa      = bus.we_i & (~full_q | ra);
    assign evt_inc = wa & bus.data_i[W-1];
    assign evt_dec = ra & eoe_mem[hptr];

    always_comb begin
        level_nxt = level;
        if (wa && !ra)
            level_nxt = level + ONE_V;
        else if (ra && !wa)
            level_nxt = level - ONE_V;
        evt_nxt = evt_cnt;
        if (evt_inc && !evt_dec)
            evt_nxt = evt_cnt + ONE_V;
        else if (evt_dec && !evt_inc)
            evt_nxt = evt_cnt - ONE_V;
    end

    always_ff @(posedge clk_i) begin
        if (wa && !clr_i) begin
            mem[wptr]     <= bus.data_i;
            eoe_mem[wptr] <= bus.data_i[W-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr       <= '0;
            hptr       <= '0;
            level      <= '0;
            evt_cnt    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            wm_high_q  <= 1'b0;
            wm_low_q   <= 1'b1;
            throttle_q <= 1'b0;
            avail_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else if (clr_i) begin
            wptr       <= '0;
            hptr       <= '0;
            level      <= '0;
            evt_cnt    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            wm_high_q  <= 1'b0;
            wm_low_q   <= 1'b1;
            throttle_q <= 1'b0;
            avail_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            if (wa) wptr <= wptr + 1'b1;
            if (ra) hptr <= hptr + 1'b1;
            level     <= level_nxt;
            evt_cnt   <= evt_nxt;
            empty_q   <= ~out_vld_nxt;
            full_q    <= (level_nxt == N_V);
            wm_high_q <= (level_nxt >= HIGH_V);
            wm_low_q  <= (level_nxt < LOW_V);
            if (level_nxt >= HIGH_V)
                throttle_q <= 1'b1;
            else if (level_nxt < LOW_V)
                throttle_q <= 1'b0;
            avail_q   <= (evt_nxt != '0);
            ovf_q     <= ovf_q | (bus.we_i & ~wa);
            udf_q     <= udf_q | (bus.re_i & ~ra);
        end
    end

    if (SHOWAHEAD) begin : g_showahead
        // RAM read register (mid) feeds the output register; empty_o is the
        // output-valid flag, so level counts words in RAM, mid and output.
        logic [AW-1:0] rptr;
        logic [W-1:0]  mid_q;
        logic          mid_vld, mid_move, rd_en;
        logic [AW:0]   ram_words;

        assign ram_words   = level - {{AW{1'b0}}, ~empty_q} - {{AW{1'b0}}, mid_vld};
        assign mid_move    = mid_vld & (empty_q | ra);
        assign rd_en       = (ram_words != '0) & (~mid_vld | mid_move);
        assign out_vld_nxt = mid_move | (~empty_q & ~ra);

        always_ff @(posedge clk_i) begin
            if (rd_en) mid_q <= mem[rptr];
        end

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                rptr    <= '0;
                mid_vld <= 1'b0;
                data_q  <= '0;
            end else if (clr_i) begin
                rptr    <= '0;
                mid_vld <= 1'b0;
                data_q  <= '0;
            end else begin
                if (rd_en) rptr <= rptr + 1'b1;
                mid_vld <= rd_en | (mid_vld & ~mid_move);
                if (mid_move) data_q <= mid_q;
            end
        end
    end else begin : g_normal
        assign out_vld_nxt = (level_nxt != '0);

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i)
                data_q <= '0;
            else if (clr_i)
                data_q <= '0;
            else if (ra)
                data_q <= mem[hptr];
        end
    end

    assign bus.data_o           = data_q;
    assign bus.empty_o          = empty_q;
    assign bus.full_o           = full_q;
    assign bus.level_o          = level;
    assign bus.watermark_high_o = wm_high_q;
    assign bus.watermark_low_o  = wm_low_q;
    assign bus.throttle_o       = throttle_q;
    assign bus.evt_cnt_o        = evt_cnt;
    assign bus.evt_avail_o      = avail_q;
    assign bus.overflow_o       = ovf_q;
    assign bus.underflow_o      = udf_q;
endmodule

// File: tb/tb_evt_fifo_gen.sv
// Directed bench for evt_fifo_gen: one normal-read and one show-ahead instance
// (W=9, N=16, HIGH=12, LOW=8), table vectors plus multi-cycle sequences.
module tb_evt_fifo_gen;
    localparam int W  = 9;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic clr0, clr1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    evt_fifo_gen_if #(.W(W), .AW(AW)) if0 ();
    evt_fifo_gen_if #(.W(W), .AW(AW)) if1 ();

    evt_fifo_gen #(.W(W), .AW(AW), .HIGH(12), .LOW(8), .SHOWAHEAD(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .clr_i(clr0), .bus(if0)
    );
    evt_fifo_gen #(.W(W), .AW(AW), .HIGH(12), .LOW(8), .SHOWAHEAD(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .clr_i(clr1), .bus(if1)
    );

    logic [26:0] st0, st1;
    assign st0 = {if0.data_o, if0.empty_o, if0.full_o, if0.level_o, if0.evt_cnt_o, if0.evt_avail_o,
                  if0.overflow_o, if0.underflow_o, if0.watermark_high_o, if0.watermark_low_o, if0.throttle_o};
    assign st1 = {if1.data_o, if1.empty_o, if1.full_o, if1.level_o, if1.evt_cnt_o, if1.evt_avail_o,
                  if1.overflow_o, if1.underflow_o, if1.watermark_high_o, if1.watermark_low_o, if1.throttle_o};

    // Expected status word; avail and watermarks follow from count and level.
    function automatic logic [26:0] mk(input logic [8:0] d, input logic e, input logic f,
                                       input logic [4:0] l, input logic [4:0] ev,
                                       input logic ov, input logic un, input logic th);
        return {d, e, f, l, ev, (ev != 5'd0), ov, un, (l >= 5'd12), (l < 5'd8), th};
    endfunction

    function automatic logic [8:0] wv(input int i);
        return {i[0], 8'(i * 7 + 3)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       we;
        logic       re;
        logic [8:0] din;
        logic [8:0] dout;
        logic       emp;
        logic [4:0] lvl;
        logic [4:0] evt;
        logic       udf;
    } vec_t;

    vec_t tv[12];

    initial begin
        logic [8:0] d;
        logic [8:0] nx;
        tv[0]  = '{1'b1, 1'b0, 9'h0AA, 9'h000, 1'b0, 5'd1, 5'd0, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 9'h0BB, 9'h000, 1'b0, 5'd2, 5'd0, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 9'h1CC, 9'h000, 1'b0, 5'd3, 5'd1, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 5'd3, 5'd1, 1'b0};
        tv[4]  = '{1'b0, 1'b1, 9'h000, 9'h0AA, 1'b0, 5'd2, 5'd1, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 9'h000, 9'h0BB, 1'b0, 5'd1, 5'd1, 1'b0};
        tv[6]  = '{1'b0, 1'b1, 9'h000, 9'h1CC, 1'b1, 5'd0, 5'd0, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 9'h000, 9'h1CC, 1'b1, 5'd0, 5'd0, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 9'h000, 9'h1CC, 1'b1, 5'd0, 5'd0, 1'b1};
        tv[9]  = '{1'b1, 1'b1, 9'h1DD, 9'h1CC, 1'b0, 5'd1, 5'd1, 1'b1};
        tv[10] = '{1'b1, 1'b1, 9'h0EE, 9'h1DD, 1'b0, 5'd1, 5'd0, 1'b1};
        tv[11] = '{1'b0, 1'b1, 9'h000, 9'h0EE, 1'b1, 5'd0, 5'd0, 1'b1};

        rst_n = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0;
        if0.we_i = 1'b0; if0.re_i = 1'b0; if0.data_i = '0;
        if1.we_i = 1'b0; if1.re_i = 1'b0; if1.data_i = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("reset_normal", 32'(st0), 32'(mk(9'h000, 1, 0, 5'd0, 5'd0, 0, 0, 0)));
        chk("reset_showahead", 32'(st1), 32'(mk(9'h000, 1, 0, 5'd0, 5'd0, 0, 0, 0)));

        // Normal-read table: writes, reads, underflow, write/read on empty and on one word
        for (int i = 0; i < 12; i++) begin
            if0.we_i = tv[i].we; if0.re_i = tv[i].re; if0.data_i = tv[i].din;
            step();
            chk($sformatf("vec%0d", i), 32'(st0),
                32'(mk(tv[i].dout, tv[i].emp, 0, tv[i].lvl, tv[i].evt, 0, tv[i].udf, 0)));
        end
        if0.we_i = 1'b0; if0.re_i = 1'b0;

        // Clear beats a simultaneous write
        clr0 = 1'b1; if0.we_i = 1'b1; if0.data_i = 9'h1FF;
        step();
        clr0 = 1'b0; if0.we_i = 1'b0;
        chk("clr_normal", 32'(st0), 32'(mk(9'h000, 1, 0, 5'd0, 5'd0, 0, 0, 0)));

        // Fill 17 words: full after 16, 17th dropped, throttle from level 12
        for (int k = 1; k <= 17; k++) begin
            if0.we_i = 1'b1; if0.data_i = 9'h010 + 9'(k - 1);
            step();
            chk($sformatf("fill%0d", k), 32'(st0),
                32'(mk(9'h000, 0, (k >= 16), (k >= 16) ? 5'd16 : 5'(k), 5'd0, (k == 17), 0, (k >= 12))));
        end

        // Full with write and read together: write accepted, level stays 16
        if0.we_i = 1'b1; if0.re_i = 1'b1; if0.data_i = 9'h0F0;
        step();
        chk("full_wr_rd", 32'(st0), 32'(mk(9'h010, 0, 1, 5'd16, 5'd0, 1, 0, 1)));

        // Drain: 0x011..0x01F then 0x0F0; throttle holds down to level 8
        if0.we_i = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            step();
            d = (j == 16) ? 9'h0F0 : 9'h010 + 9'(j);
            chk($sformatf("drain%0d", j), 32'(st0),
                32'(mk(d, (j == 16), 0, 5'(16 - j), 5'd0, 1, 0, (16 - j) >= 8)));
        end
        if0.re_i = 1'b0;

        // 40 push/pop cycles across pointer wrap
        if0.we_i = 1'b1; if0.data_i = wv(0);
        step();
        if0.re_i = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if0.data_i = wv(i);
            step();
            nx = wv(i);
            chk($sformatf("wrap%0d", i), {if0.data_o, if0.level_o, if0.evt_cnt_o},
                {wv(i - 1), 5'd1, 4'd0, nx[8]});
        end
        if0.we_i = 1'b0;
        step();
        if0.re_i = 1'b0;
        chk("wrap_last", {if0.data_o, if0.level_o, if0.evt_cnt_o, if0.empty_o},
            {wv(40), 5'd0, 5'd0, 1'b1});

        // Show-ahead: write into empty appears two cycles later
        if1.we_i = 1'b1; if1.data_i = 9'h155;
        step();
        if1.we_i = 1'b0;
        chk("sa_e0", {if1.empty_o, if1.level_o, if1.evt_cnt_o}, {1'b1, 5'd1, 5'd1});
        step();
        chk("sa_e1", {if1.empty_o, if1.level_o, if1.evt_cnt_o}, {1'b1, 5'd1, 5'd1});
        step();
        chk("sa_e2", 32'(st1), 32'(mk(9'h155, 0, 0, 5'd1, 5'd1, 0, 0, 0)));

        if1.we_i = 1'b1; if1.data_i = 9'h0AB;
        step();
        if1.data_i = 9'h0CD;
        step();
        if1.we_i = 1'b0;
        chk("sa_head_hold", 32'(st1), 32'(mk(9'h155, 0, 0, 5'd3, 5'd1, 0, 0, 0)));
        if1.re_i = 1'b1;
        step();
        chk("sa_rd1", 32'(st1), 32'(mk(9'h0AB, 0, 0, 5'd2, 5'd0, 0, 0, 0)));
        step();
        chk("sa_rd2", 32'(st1), 32'(mk(9'h0CD, 0, 0, 5'd1, 5'd0, 0, 0, 0)));
        step();
        chk("sa_rd3", 32'(st1), 32'(mk(9'h0CD, 1, 0, 5'd0, 5'd0, 0, 0, 0)));
        step();
        if1.re_i = 1'b0;
        chk("sa_underflow", 32'(st1), 32'(mk(9'h0CD, 1, 0, 5'd0, 5'd0, 0, 1, 0)));

        // Fill 13 words (6 with EOE), then clear mid-fill with write and read pending
        for (int k = 0; k < 13; k++) begin
            if1.we_i = 1'b1; if1.data_i = wv(k);
            step();
        end
        if1.we_i = 1'b0;
        chk("sa_fill13", 32'(st1), 32'(mk(wv(0), 0, 0, 5'd13, 5'd6, 0, 1, 1)));
        clr1 = 1'b1; if1.we_i = 1'b1; if1.re_i = 1'b1; if1.data_i = 9'h1EE;
        step();
        clr1 = 1'b0; if1.we_i = 1'b0; if1.re_i = 1'b0;
        chk("sa_clr", 32'(st1), 32'(mk(9'h000, 1, 0, 5'd0, 5'd0, 0, 0, 0)));

        if1.we_i = 1'b1; if1.data_i = 9'h077;
        step();
        if1.we_i = 1'b0;
        step();
        chk("sa_post_clr_e1", {if1.empty_o, if1.level_o}, {1'b1, 5'd1});
        step();
        chk("sa_post_clr_e2", {if1.data_o, if1.empty_o, if1.level_o}, {9'h077, 1'b0, 5'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
